// File: rtl/npu_layer_seq.sv
// Layer sequencer for a two-stage NPU: launches the conv engine, then the fcn engine,
// captures the final logit and keeps sticky done/err status plus a saturating run count.
module npu_layer_seq #(
    parameter int TIMEOUT = 4096,
    parameter int RES_W   = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    input  logic [1:0]              cmd_op,
    output logic                    cmd_ready,
    output logic                    conv_start,
    input  logic                    conv_done,
    output logic                    fcn_start,
    input  logic                    fcn_done,
    input  logic signed [RES_W-1:0] fcn_logit,
    input  logic                    load_req,
    output logic                    load_grant,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic signed [RES_W-1:0] result,
    output logic [7:0]              run_count
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] OP_START = 2'b01;
    localparam logic [1:0] OP_ABORT = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CONV_START,
        CONV_WAIT,
        FCN_START,
        FCN_WAIT
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   wait_cnt;

    logic cmd_start;
    logic cmd_abort;
    logic cmd_clear;
    logic in_wait;
    logic wait_hit;
    logic wait_expired;
    logic run_begin;
    logic run_complete;
    logic run_timeout;

    assign cmd_start = cmd_valid && (cmd_op == OP_START);
    assign cmd_abort = cmd_valid && (cmd_op == OP_ABORT);
    assign cmd_clear = cmd_valid && (cmd_op == OP_CLEAR);

    // Each engine's done only counts inside its own WAIT state; elsewhere it is dropped.
    assign in_wait      = (state == CONV_WAIT) || (state == FCN_WAIT);
    assign wait_hit     = ((state == CONV_WAIT) && conv_done) || ((state == FCN_WAIT) && fcn_done);
    assign wait_expired = in_wait && !wait_hit && (wait_cnt == CNT_W'(TIMEOUT - 1));

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        state_next   = state;
        run_begin    = 1'b0;
        run_complete = 1'b0;
        run_timeout  = 1'b0;
        unique case (state)
            IDLE: begin
                if (cmd_start) begin
                    state_next = CONV_START;
                    run_begin  = 1'b1;
                end
            end
            CONV_START: state_next = CONV_WAIT;
            CONV_WAIT: begin
                if (wait_hit) begin
                    state_next = FCN_START;
                end else if (wait_expired) begin
                    state_next  = IDLE;
                    run_timeout = 1'b1;
                end
            end
            FCN_START: state_next = FCN_WAIT;
            FCN_WAIT: begin
                if (wait_hit) begin
                    state_next   = IDLE;
                    run_complete = 1'b1;
                end else if (wait_expired) begin
                    state_next  = IDLE;
                    run_timeout = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        // Abort outranks a same-cycle completion or timeout: the run leaves no trace.
        if (cmd_abort && (state != IDLE)) begin
            state_next   = IDLE;
            run_complete = 1'b0;
            run_timeout  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            result    <= '0;
            run_count <= '0;
        end else begin
            state <= state_next;

            // Counter restarts whenever a WAIT state is entered or left.
            if (in_wait && (state_next == state)) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end else begin
                wait_cnt <= '0;
            end

            if (cmd_clear || run_begin) begin
                done <= 1'b0;
                err  <= 1'b0;
            end
            if (run_complete) begin
                done   <= 1'b1;
                result <= fcn_logit;
                if (run_count != 8'hFF) begin
                    run_count <= run_count + 8'd1;
                end
            end
            if (run_timeout) begin
                err <= 1'b1;
            end
        end
    end

    assign cmd_ready  = 1'b1;
    assign conv_start = (state == CONV_START);
    assign fcn_start  = (state == FCN_START);
    assign busy       = (state != IDLE);
    assign load_grant = load_req && (state == IDLE);

endmodule

// File: tb/tb_npu_layer_seq.sv
// Directed bench for npu_layer_seq: normal run, ignored stray dones, abort races,
// status clear, start-while-busy, timeout, count saturation and mid-run reset.
module tb_npu_layer_seq;

    localparam int TIMEOUT = 8;
    localparam int RES_W   = 24;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    cmd_valid;
    logic [1:0]              cmd_op;
    logic                    cmd_ready;
    logic                    conv_start;
    logic                    conv_done;
    logic                    fcn_start;
    logic                    fcn_done;
    logic signed [RES_W-1:0] fcn_logit;
    logic                    load_req;
    logic                    load_grant;
    logic                    busy;
    logic                    done;
    logic                    err;
    logic signed [RES_W-1:0] result;
    logic [7:0]              run_count;

    int tests  = 0;
    int failed = 0;

    npu_layer_seq #(.TIMEOUT(TIMEOUT), .RES_W(RES_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_op     (cmd_op),
        .cmd_ready  (cmd_ready),
        .conv_start (conv_start),
        .conv_done  (conv_done),
        .fcn_start  (fcn_start),
        .fcn_done   (fcn_done),
        .fcn_logit  (fcn_logit),
        .load_req   (load_req),
        .load_grant (load_grant),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .result     (result),
        .run_count  (run_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs for the new cycle are driven right after.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [1:0] op);
        cmd_valid = 1'b1;
        cmd_op    = op;
    endtask

    task automatic no_cmd();
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
    endtask

    // Minimum-latency run: start, conv_done and fcn_done on the first WAIT cycles.
    task automatic fast_run(input logic signed [RES_W-1:0] logit);
        cmd(2'b01);
        tick(); no_cmd();                                   // CONV_START
        tick(); conv_done = 1'b1;                           // CONV_WAIT
        tick(); conv_done = 1'b0;                           // FCN_START
        tick(); fcn_done = 1'b1; fcn_logit = logit;         // FCN_WAIT
        tick(); fcn_done = 1'b0;                            // IDLE
    endtask

    int pulses;

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        conv_done = 1'b0;
        fcn_done  = 1'b0;
        fcn_logit = '0;
        load_req  = 1'b1;

        // Reset state
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_result", {8'd0, result}, 32'd0);
        check("rst_count", {24'd0, run_count}, 32'd0);
        check("rst_pulses", {30'd0, conv_start, fcn_start}, 32'd0);
        check("cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("grant_idle_before", {31'd0, load_grant}, 32'd1);

        // Normal run: start at t, conv_done at t+2, fcn_done(-5) at t+4
        tick(); cmd(2'b01); #1;                                               // t
        check("t0_busy", {31'd0, busy}, 32'd0);
        tick(); no_cmd(); #1;                                                 // t+1
        check("t1_conv_start", {31'd0, conv_start}, 32'd1);
        check("t1_fcn_start", {31'd0, fcn_start}, 32'd0);
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_grant", {31'd0, load_grant}, 32'd0);
        tick(); conv_done = 1'b1; #1;                                         // t+2
        check("t2_conv_start", {31'd0, conv_start}, 32'd0);
        check("t2_grant", {31'd0, load_grant}, 32'd0);
        tick(); conv_done = 1'b0; #1;                                         // t+3
        check("t3_fcn_start", {31'd0, fcn_start}, 32'd1);
        check("t3_conv_start", {31'd0, conv_start}, 32'd0);
        check("t3_grant", {31'd0, load_grant}, 32'd0);
        tick(); fcn_done = 1'b1; fcn_logit = -24'sd5; #1;                     // t+4
        check("t4_fcn_start", {31'd0, fcn_start}, 32'd0);
        check("t4_grant", {31'd0, load_grant}, 32'd0);
        check("t4_done_not_yet", {31'd0, done}, 32'd0);
        tick(); fcn_done = 1'b0; fcn_logit = '0; #1;                          // t+5
        check("t5_done", {31'd0, done}, 32'd1);
        check("t5_result", {8'd0, result}, 32'hFFFFFB);
        check("t5_count", {24'd0, run_count}, 32'd1);
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("grant_idle_after", {31'd0, load_grant}, 32'd1);

        // Stray conv_done in CONV_START is dropped; abort + fcn_done in FCN_WAIT: abort wins
        cmd(2'b01);
        tick(); no_cmd(); conv_done = 1'b1; #1;                               // CONV_START
        check("r2_done_cleared", {31'd0, done}, 32'd0);
        tick(); conv_done = 1'b0; #1;                                         // CONV_WAIT
        tick(); #1;                                                           // still CONV_WAIT
        check("r2_stray_done_ignored", {30'd0, fcn_start, busy}, 32'd1);
        conv_done = 1'b1;
        tick(); conv_done = 1'b0; #1;                                         // FCN_START
        check("r2_fcn_start", {31'd0, fcn_start}, 32'd1);
        tick(); cmd(2'b10); fcn_done = 1'b1; fcn_logit = 24'sd7; #1;          // FCN_WAIT
        tick(); no_cmd(); fcn_done = 1'b0; #1;
        check("abort_idle", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_result", {8'd0, result}, 32'hFFFFFB);
        check("abort_count", {24'd0, run_count}, 32'd1);

        // Completed run then clear status
        fast_run(24'sh000123);
        #1;
        check("r3_done", {31'd0, done}, 32'd1);
        check("r3_count", {24'd0, run_count}, 32'd2);
        cmd(2'b11);
        tick(); no_cmd(); #1;
        check("clr_done", {31'd0, done}, 32'd0);
        check("clr_result", {8'd0, result}, 32'h000123);
        check("clr_count", {24'd0, run_count}, 32'd2);

        // Start while busy is ignored, then conv timeout after 8 CONV_WAIT cycles
        cmd(2'b01);                                                           // t
        tick(); no_cmd(); #1;                                                 // t+1 CONV_START
        tick(); cmd(2'b01); #1;                                               // t+2 first CONV_WAIT
        pulses = 0;
        tick(); no_cmd(); #1;                                                 // t+3
        check("busy_start_no_pulse", {31'd0, conv_start}, 32'd0);
        for (int i = 4; i <= 9; i++) begin
            pulses += int'(conv_start) + int'(fcn_start);
            tick(); #1;
        end
        // Now at t+9: 8th CONV_WAIT cycle
        check("to_still_busy", {31'd0, busy}, 32'd1);
        tick(); #1;                                                           // t+10
        check("to_busy", {31'd0, busy}, 32'd0);
        check("to_err", {31'd0, err}, 32'd1);
        check("to_done", {31'd0, done}, 32'd0);
        check("to_result", {8'd0, result}, 32'h000123);
        check("to_no_pulses", pulses, 32'd0);

        // Abort in IDLE is a no-op
        cmd(2'b10);
        tick(); no_cmd(); #1;
        check("idle_abort_err", {30'd0, err, busy}, 32'd2);

        // Saturation: 260 more runs push the count from 2 past 255
        for (int i = 0; i < 260; i++) begin
            fast_run(24'(i));
        end
        #1;
        check("sat_count", {24'd0, run_count}, 32'd255);
        check("sat_result", {8'd0, result}, 32'd259);

        // Reset mid CONV_WAIT with a simultaneous done and command
        cmd(2'b01);
        tick(); no_cmd(); #1;                                                 // CONV_START
        tick(); rst = 1'b1; conv_done = 1'b1; cmd(2'b11); #1;                 // CONV_WAIT
        tick(); rst = 1'b0; conv_done = 1'b0; no_cmd(); #1;
        check("mid_rst_state", {27'd0, busy, done, err, conv_start, fcn_start}, 32'd0);
        check("mid_rst_result", {8'd0, result}, 32'd0);
        check("mid_rst_count", {24'd0, run_count}, 32'd0);
        tick(); #1;
        check("mid_rst_quiet", {29'd0, busy, conv_start, fcn_start}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/npu_layer_seq.md
NPU_LAYER_SEQ -- requirements
Module: npu_layer_seq

Interface
REQ-001 Parameters, one per line:
- TIMEOUT, default 4096: max cycles spent in a wait state before abort-on-timeout.
- RES_W, default 24: logit/result width.
REQ-002 Ports, one per line:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  host command strobe.
- cmd_op  in  2  command: 00 nop, 01 start, 10 abort, 11 clear status.
- cmd_ready  out  1  constant 1; every command is accepted on the cycle it is presented.
- conv_start  out  1  one-cycle pulse that launches the conv engine.
- conv_done  in  1  conv engine completion.
- fcn_start  out  1  one-cycle pulse that launches the fcn engine.
- fcn_done  in  1  fcn engine completion.
- fcn_logit  in  RES_W  signed fcn result, valid while fcn_done=1.
- load_req  in  1  host attempts an image or weight buffer write.
- load_grant  out  1  buffer write permitted.
- busy  out  1  sequence in progress.
- done  out  1  sticky: last run completed.
- err  out  1  sticky: last run timed out.
- result  out  RES_W  captured logit.
- run_count  out  8  completed runs, saturating at 255.

Function
REQ-003 States: IDLE, CONV_START, CONV_WAIT, FCN_START, FCN_WAIT.
REQ-004 IDLE + start command -> CONV_START; on the same edge, done and err clear to 0.
REQ-005 CONV_START drives conv_start=1 for exactly that cycle, then moves unconditionally to CONV_WAIT.
REQ-006 CONV_WAIT samples conv_done; when conv_done=1 -> FCN_START.
REQ-007 FCN_START drives fcn_start=1 for exactly that cycle, then moves to FCN_WAIT.
REQ-008 FCN_WAIT: on fcn_done=1 -> IDLE; on that edge result<=fcn_logit, done<=1, and run_count increments (saturates at 255).
REQ-009 conv_done and fcn_done are ignored outside their own WAIT state; a done seen in a START state is not remembered.
REQ-010 Wait counter:
- clears on entry to each WAIT state;
- increments every WAIT cycle without the matching done;
- if TIMEOUT consecutive WAIT cycles pass with no done -> IDLE, err<=1, done stays 0, result unchanged.
REQ-011 Done and timeout in the same cycle: done wins.
REQ-012 Abort in any non-IDLE state -> IDLE on the next edge, no start pulse, result/done/err unchanged. Abort in IDLE is a no-op.
REQ-013 Abort and fcn_done in the same cycle: abort wins; result, done and run_count are not updated.
REQ-014 Start while busy is ignored, with no effect on state or status.
REQ-015 Clear status (11) clears done and err in any state; state, result and run_count are unaffected.
REQ-016 busy = (state != IDLE), combinational from state.
REQ-017 load_grant = load_req AND state==IDLE, combinational; buffer writes are blocked for the whole run.
REQ-018 Minimum latency: start accepted at edge t -> conv_start high cycle t+1. With conv_done and fcn_done each asserted on the first WAIT cycle: fcn_start high cycle t+3, done=1 visible cycle t+5.
REQ-019 conv_start and fcn_start are never high in the same cycle; each pulses at most once per run.

Reset
REQ-020 When rst=1 at a rising edge:
- state -> IDLE;
- conv_start, fcn_start, busy, done, err = 0;
- result = 0, run_count = 0, wait counter = 0.
REQ-021 Reset mid-run discards the run with no pulses; rst overrides any simultaneous command or done.

Verification
REQ-022 Normal run: start at t, conv_done at t+2, fcn_done with logit -5 at t+4 -> conv_start pulse t+1, fcn_start pulse t+3, done=1, result=-5 (sign-extended in RES_W), run_count=1, busy=0 at t+5.
REQ-023 Timeout: TIMEOUT=8, start, conv_done never asserted -> err=1 and busy=0 after 8 CONV_WAIT cycles; fcn_start never pulses.
REQ-024 Abort during FCN_WAIT with fcn_done in the same cycle -> IDLE next cycle, done=0, result holds its prior value, run_count unchanged.
REQ-025 load_req held high across a run -> load_grant=0 from CONV_START through FCN_WAIT, and 1 in IDLE before and after.
REQ-026 Saturation and reset: 256 back-to-back runs -> run_count=255. A start issued while busy -> no extra pulse. rst asserted mid CONV_WAIT -> all outputs at reset values next cycle.
